// File: rtl/firebird7_in_gate2_ijtag_access_seq_if.sv
`default_nettype none
// ============================================================================
// Module : firebird7_in_gate2_ijtag_access_seq_if
// Brief  : Host request/response bus of the IJTAG access sequencer.
// Rev    : 1.0
// ============================================================================
interface firebird7_in_gate2_ijtag_access_seq_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
);
  logic               req_valid;
  logic               req_ready;
  logic [LEN_W-1:0]   req_len;
  logic [MAX_LEN-1:0] req_data;
  logic               req_capture;
  logic               req_update;
  logic               abort;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output req_valid, req_len, req_data, req_capture, req_update, abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_len, req_data, req_capture, req_update, abort, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/firebird7_in_gate2_ijtag_access_seq.sv
`default_nettype none
// ============================================================================
// Module : firebird7_in_gate2_ijtag_access_seq
// Brief  : Capture/shift/update access sequencer driving an IJTAG network.
// Rev    : 1.0
// ============================================================================
module firebird7_in_gate2_ijtag_access_seq #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  wire logic                                     ijtag_tck,
  input  wire logic                                     ijtag_reset,
  firebird7_in_gate2_ijtag_access_seq_if.slave          bus,
  output logic                                          busy,
  output logic                                          ijtag_sel,
  output logic                                          ijtag_ce,
  output logic                                          ijtag_se,
  output logic                                          ijtag_ue,
  output logic                                          ijtag_si,
  input  wire logic                                     ijtag_so
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SHIFT   = 3'd2,
    S_UPDATE  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [MAX_LEN-1:0]   data_q;
  logic [MAX_LEN-1:0]   rsp_q;
  logic                 cap_q;
  logic                 upd_q;

  logic [LEN_W-1:0]     w_eff_len;
  logic                 w_accept;
  logic                 w_last_bit;
  logic [IDX_W-1:0]     w_idx;

  assign w_eff_len  = (bus.req_len > C_MAX_LEN) ? C_MAX_LEN : bus.req_len;
  assign w_accept   = (state_q == S_IDLE) && bus.req_valid;
  assign w_last_bit = (cnt_q == (len_q - LEN_W'(1)));
  // The counter never reaches MAX_LEN inside SHIFT, so the low bits suffice.
  assign w_idx      = cnt_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          if (bus.req_capture)            state_d = S_CAPTURE;
          else if (w_eff_len != '0)       state_d = S_SHIFT;
          else if (bus.req_update)        state_d = S_UPDATE;
          else                            state_d = S_RESP;
        end
      end
      S_CAPTURE: begin
        cnt_d = '0;
        if (bus.abort)                    state_d = S_IDLE;
        else if (len_q != '0)             state_d = S_SHIFT;
        else if (upd_q)                   state_d = S_UPDATE;
        else                              state_d = S_RESP;
      end
      S_SHIFT: begin
        if (bus.abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (w_last_bit) begin
          cnt_d   = '0;
          state_d = upd_q ? S_UPDATE : S_RESP;
        end else begin
          cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      S_UPDATE: begin
        state_d = bus.abort ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready)                state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= 1'b0;
      upd_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        len_q  <= w_eff_len;
        data_q <= bus.req_data;
        cap_q  <= bus.req_capture;
        upd_q  <= bus.req_update;
        // Bits beyond the shift length must read back as zero.
        rsp_q  <= '0;
      end else if (state_q == S_SHIFT) begin
        rsp_q[w_idx] <= ijtag_so;
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_q;
  assign busy          = (state_q != S_IDLE);
  assign ijtag_ce      = (state_q == S_CAPTURE);
  assign ijtag_se      = (state_q == S_SHIFT);
  assign ijtag_ue      = (state_q == S_UPDATE);
  assign ijtag_sel     = ijtag_ce | ijtag_se | ijtag_ue;
  assign ijtag_si      = ijtag_se & data_q[w_idx];

  // cap_q is kept for observability of the latched request.
  logic w_unused;
  assign w_unused = cap_q;

endmodule
`default_nettype wire

// File: tb/tb_firebird7_in_gate2_ijtag_access_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_firebird7_in_gate2_ijtag_access_seq
// Brief  : Self-checking bench for the IJTAG access sequencer.
// Rev    : 1.0
// ============================================================================
module tb_firebird7_in_gate2_ijtag_access_seq;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic ijtag_tck;
  logic ijtag_reset;
  logic busy, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_so;

  int errors = 0;
  int checks = 0;

  firebird7_in_gate2_ijtag_access_seq_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  firebird7_in_gate2_ijtag_access_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .bus         (bus.slave),
    .busy        (busy),
    .ijtag_sel   (ijtag_sel),
    .ijtag_ce    (ijtag_ce),
    .ijtag_se    (ijtag_se),
    .ijtag_ue    (ijtag_ue),
    .ijtag_si    (ijtag_si),
    .ijtag_so    (ijtag_so)
  );

  initial ijtag_tck = 1'b0;
  always #5 ijtag_tck = ~ijtag_tck;

  // {sel, ce, se, ue, si, busy, req_ready, rsp_valid}
  function automatic logic [7:0] obs_vec();
    return {ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, busy,
            bus.req_ready, bus.rsp_valid};
  endfunction

  localparam logic [7:0] V_IDLE = 8'b0000_0010;
  localparam logic [7:0] V_RESP = 8'b0000_0101;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: an access is the phase list [C]? S*min(len,MAX) [U]?, then RESP.
  // Abort/reset at phase index p ends the access with no response.
  task automatic access(input int len, input logic [31:0] data, input bit cap,
                        input bit upd, input logic [31:0] so_word,
                        input int abort_at, input int reset_at, input int bp,
                        output logic [31:0] got);
    byte         phase[$];
    int          el;
    int          k;
    logic [31:0] exp_rsp;
    logic [31:0] held;
    logic [7:0]  v;
    el = (len > MAX_LEN) ? MAX_LEN : len;
    if (cap) phase.push_back("C");
    for (int i = 0; i < el; i++) phase.push_back("S");
    if (upd) phase.push_back("U");
    exp_rsp = '0;
    got = '0;

    chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid   = 1'b1;
    bus.req_len     = LEN_W'(len);
    bus.req_data    = data;
    bus.req_capture = cap;
    bus.req_update  = upd;
    @(posedge ijtag_tck); #1;

    k = 0;
    for (int p = 0; p < phase.size(); p++) begin
      v = {1'b1, phase[p] == "C", phase[p] == "S", phase[p] == "U",
           (phase[p] == "S") ? data[k] : 1'b0, 1'b1, 1'b0, 1'b0};
      chk($sformatf("phase%0d_%s", p, string'(phase[p])), {24'd0, obs_vec()}, {24'd0, v});
      if (phase[p] == "S") begin
        ijtag_so = so_word[k];
        exp_rsp[k] = so_word[k];
        k++;
      end
      // Garbage requests while busy must not disturb the latched access.
      bus.req_valid = ($urandom_range(0, 1) == 1) && (p != abort_at);
      bus.req_data  = $urandom;
      bus.req_len   = LEN_W'($urandom_range(0, 40));
      bus.req_capture = $urandom_range(0, 1) == 1;
      bus.req_update  = $urandom_range(0, 1) == 1;
      if (p == reset_at) begin
        bus.req_valid = 1'b0;
        #3 ijtag_reset = 1'b0;
        #1;
        chk("async_reset_outputs", {24'd0, obs_vec()}, {24'd0, V_IDLE});
        chk("async_reset_rsp_data", bus.rsp_data, 32'd0);
        @(posedge ijtag_tck); #1;
        chk("in_reset_idle", {24'd0, obs_vec()}, {24'd0, V_IDLE});
        @(negedge ijtag_tck);
        ijtag_reset = 1'b1;
        return;
      end
      if (p == abort_at) bus.abort = 1'b1;
      @(posedge ijtag_tck); #1;
      bus.abort = 1'b0;
      if (p == abort_at) begin
        bus.req_valid = 1'b0;
        chk("after_abort_idle", {24'd0, obs_vec()}, {24'd0, V_IDLE});
        @(posedge ijtag_tck); #1;
        chk("after_abort_quiet", {24'd0, obs_vec()}, {24'd0, V_IDLE});
        return;
      end
    end

    chk("resp_outputs", {24'd0, obs_vec()}, {24'd0, V_RESP});
    chk("resp_data", bus.rsp_data, exp_rsp);
    got  = bus.rsp_data;
    held = bus.rsp_data;
    for (int b = 0; b < bp; b++) begin
      bus.rsp_ready = 1'b0;
      bus.abort     = $urandom_range(0, 1) == 1;
      bus.req_valid = 1'b1;
      bus.req_data  = $urandom;
      @(posedge ijtag_tck); #1;
      chk($sformatf("bp%0d_outputs", b), {24'd0, obs_vec()}, {24'd0, V_RESP});
      chk($sformatf("bp%0d_data", b), bus.rsp_data, held);
    end
    bus.abort     = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge ijtag_tck); #1;
    bus.rsp_ready = 1'b0;
    chk("idle_after_resp", {24'd0, obs_vec()}, {24'd0, V_IDLE});
  endtask

  initial begin
    logic [31:0] r;
    int          len, np, ab;
    bit          cap, upd;

    ijtag_reset     = 1'b0;
    ijtag_so        = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_len     = '0;
    bus.req_data    = '0;
    bus.req_capture = 1'b0;
    bus.req_update  = 1'b0;
    bus.abort       = 1'b0;
    bus.rsp_ready   = 1'b0;
    #2;
    chk("reset_outputs", {24'd0, obs_vec()}, {24'd0, V_IDLE});
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    @(negedge ijtag_tck);
    ijtag_reset = 1'b1;

    // Full access: si = 0xA5 LSB first, so stream 0x3C.
    access(8, 32'h0000_00A5, 1'b1, 1'b1, 32'h0000_003C, -1, -1, 0, r);
    chk("full_access_rsp", r, 32'h0000_003C);

    // Zero length with update only.
    access(0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, -1, -1, 0, r);
    chk("zero_len_rsp", r, 32'd0);

    // Length clamped to MAX_LEN.
    access(40, 32'h1234_5678, 1'b0, 1'b0, 32'hDEAD_BEEF, -1, -1, 0, r);
    chk("clamp_rsp", r, 32'hDEAD_BEEF);

    // Abort in SHIFT cycle 3 of a 16-bit access.
    access(16, 32'h0000_F0F0, 1'b0, 1'b1, 32'h0000_AAAA, 3, -1, 0, r);

    // Backpressure for 5 cycles.
    access(12, 32'h0000_0ABC, 1'b1, 1'b0, 32'h0000_0F35, -1, -1, 5, r);
    chk("backpressure_rsp", r, 32'h0000_0F35);

    // Async reset mid-UPDATE, then a request on the first edge after release.
    access(4, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_000A, -1, 5, 0, r);
    access(6, 32'h0000_002B, 1'b0, 1'b1, 32'h0000_0011, -1, -1, 1, r);
    chk("post_reset_rsp", r, 32'h0000_0011);

    for (int n = 0; n < 24; n++) begin
      len = $urandom_range(0, 40);
      cap = $urandom_range(0, 1) == 1;
      upd = $urandom_range(0, 1) == 1;
      np  = ((len > MAX_LEN) ? MAX_LEN : len) + int'(cap) + int'(upd);
      ab  = (np > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, np - 1)) : -1;
      access(len, $urandom, cap, upd, $urandom, ab, -1, $urandom_range(0, 3), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
